// File: rtl/data_cache_if.sv
// Word-wide request/acknowledge bus between the L1 data cache and backing memory.
// The cache drives the request side; memory returns read data and the acknowledge.
interface data_cache_if #(
    parameter int ADDR_WIDTH = 17
);
    logic                  MemReq;
    logic                  MemWe;
    logic [ADDR_WIDTH-1:0] MemAddr;
    logic [31:0]           MemWData;
    logic [3:0]            MemByteEn;
    logic [31:0]           MemRData;
    logic                  MemAck;

    modport master (
        output MemReq, MemWe, MemAddr, MemWData, MemByteEn,
        input  MemRData, MemAck
    );

    modport slave (
        input  MemReq, MemWe, MemAddr, MemWData, MemByteEn,
        output MemRData, MemAck
    );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Hits load with zero latency; misses refill a whole line one word per acknowledged beat.
module data_cache #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            SizeCtr,
    input  logic [ADDR_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Stall,
    data_cache_if.master          mem
);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_WIDTH - IDX_W - WORD_W - 2;
    localparam int DEPTH  = SETS * LINE_WORDS;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

    state_t state_reg, state_next;
    logic [WORD_W-1:0] beat_reg, beat_next;
    logic [SETS-1:0]   valid_reg;

    logic [31:0]      data_ram [DEPTH];
    logic [TAG_W-1:0] tag_ram  [SETS];

    logic [1:0]              off;
    logic [WORD_W-1:0]       word_sel;
    logic [IDX_W-1:0]        index;
    logic [TAG_W-1:0]        tag;
    logic                    hit;
    logic [31:0]             line_word;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [3:0]              store_be;
    logic [31:0]             store_data;
    logic [31:0]             merged_word;
    logic                    ram_we;
    logic [IDX_W+WORD_W-1:0] ram_addr;
    logic [31:0]             ram_wdata;
    logic                    refill_last;

    assign off      = ALUResult[1:0];
    assign word_sel = ALUResult[WORD_W+1:2];
    assign index    = ALUResult[WORD_W+2 +: IDX_W];
    assign tag      = ALUResult[ADDR_WIDTH-1 -: TAG_W];

    assign hit       = valid_reg[index] && (tag_ram[index] == tag);
    assign line_word = data_ram[{index, word_sel}];

    // Load extraction reads the indexed line directly, valid or not.
    assign byte_sel = line_word[{off, 3'b000} +: 8];
    assign half_sel = line_word[{off[1], 4'b0000} +: 16];

    always_comb begin
        ReadData = '0;
        case (SizeCtr)
            3'b000:  ReadData = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ReadData = {{16{half_sel[15]}}, half_sel};
            3'b010:  ReadData = line_word;
            3'b100:  ReadData = {24'b0, byte_sel};
            3'b101:  ReadData = {16'b0, half_sel};
            default: ReadData = '0;
        endcase
    end

    assign store_data = WriteData << {off, 3'b000};

    always_comb begin
        store_be = 4'b1111;
        case (SizeCtr[1:0])
            2'b00:   store_be = 4'b0001 << off;
            2'b01:   store_be = 4'b0011 << off;
            default: store_be = 4'b1111;
        endcase
    end

    // A store hit rewrites only the enabled lanes of the cached word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[gi*8 +: 8] = store_be[gi] ? store_data[gi*8 +: 8]
                                                         : line_word[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        beat_next     = beat_reg;
        Stall         = 1'b0;
        mem.MemReq    = 1'b0;
        mem.MemWe     = 1'b0;
        mem.MemAddr   = '0;
        mem.MemWData  = '0;
        mem.MemByteEn = '0;
        ram_we        = 1'b0;
        ram_addr      = {index, word_sel};
        ram_wdata     = merged_word;
        refill_last   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (MemWrite) begin
                    Stall      = 1'b1;
                    state_next = WRITE;
                end else if (MemRead && !hit) begin
                    Stall      = 1'b1;
                    beat_next  = '0;
                    state_next = REFILL;
                end
            end
            REFILL: begin
                Stall       = 1'b1;
                mem.MemReq  = 1'b1;
                mem.MemAddr = {tag, index, beat_reg, 2'b00};
                ram_addr    = {index, beat_reg};
                ram_wdata   = mem.MemRData;
                if (mem.MemAck) begin
                    ram_we    = 1'b1;
                    beat_next = beat_reg + WORD_W'(1);
                    if (beat_reg == LAST_BEAT) begin
                        refill_last = 1'b1;
                        state_next  = IDLE;
                    end
                end
            end
            WRITE: begin
                Stall         = 1'b1;
                mem.MemReq    = 1'b1;
                mem.MemWe     = 1'b1;
                mem.MemAddr   = {ALUResult[ADDR_WIDTH-1:2], 2'b00};
                mem.MemWData  = store_data;
                mem.MemByteEn = store_be;
                if (mem.MemAck) begin
                    ram_we     = hit;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            beat_reg  <= '0;
            valid_reg <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
            // Valid rises only on the final beat, so an interrupted refill leaves the line invalid.
            if (refill_last)
                valid_reg[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            data_ram[ram_addr] <= ram_wdata;
        if (refill_last)
            tag_ram[index] <= tag;
    end
endmodule
